// File: rtl/utmi_pkg.sv
// Shared types and defaults for the UTMI transmit scheduler.
package utmi_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned DEF_TURNAROUND = 8;
  localparam int unsigned DEF_IPG        = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/utmi_rr_pick.sv
// Combinational round-robin select: first requester at or after ptr_i, wrapping.
module utmi_rr_pick
  import utmi_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [PTR_W-1:0]   idx_o
);

  logic        found;
  int unsigned pos;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    pos     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = 32'(ptr_i) + k;
      if (pos >= NUM_REQ) begin
        pos = pos - NUM_REQ;
      end
      if (!found && req_i[PTR_W'(pos)]) begin
        found                  = 1'b1;
        grant_o[PTR_W'(pos)]   = 1'b1;
        idx_o                  = PTR_W'(pos);
      end
    end
  end

endmodule

// File: rtl/utmi_tx_sched.sv
// Round-robin owner of the UTMI TX path with RX turnaround and inter-packet gap.
// Define UTMI_TX_WDOG_EN to abort packets that reach MAX_LEN bytes without a last byte.
module utmi_tx_sched
  import utmi_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned TURNAROUND = DEF_TURNAROUND,
  parameter int unsigned IPG        = DEF_IPG,
  parameter int unsigned MAX_LEN    = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]        req_last_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      tx_valid_o,
  output logic [BYTE_W-1:0]         tx_data_o,
  input  logic                      tx_ready_i,
  input  logic                      rx_active_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      busy_o,
  output logic                      pkt_done_o,
  output logic                      tx_abort_o
);

  localparam int unsigned PTR_W  = cnt_w(NUM_REQ - 1);
  localparam int unsigned TURN_W = cnt_w(TURNAROUND);
  localparam int unsigned GAP_W  = cnt_w(IPG);

  state_t              state_q;
  logic [PTR_W-1:0]    ptr_q;
  logic [PTR_W-1:0]    ptr_d;
  logic [PTR_W-1:0]    gidx_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [TURN_W-1:0]   turn_q;
  logic [TURN_W-1:0]   turn_d;
  logic [GAP_W-1:0]    gap_q;

  logic [NUM_REQ-1:0]  pick_grant;
  logic [PTR_W-1:0]    pick_idx;
  logic [BYTE_W-1:0]   req_byte [NUM_REQ];

  logic sending;
  logic g_valid;
  logic g_last;
  logic accept;
  logic underrun;
  logic wdog_trip;
  logic pkt_end;
  logic grant_ok;
  logic gap_last;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_byte[i] = req_data_i[i*BYTE_W +: BYTE_W];
  end

  utmi_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req_i   (req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx)
  );

  // The granted source is passed straight through so its handshake sees TX_READY directly.
  assign sending     = (state_q == ST_SEND);
  assign g_valid     = req_valid_i[gidx_q];
  assign g_last      = req_last_i[gidx_q];
  assign tx_valid_o  = sending & g_valid;
  assign tx_data_o   = tx_valid_o ? req_byte[gidx_q] : '0;
  assign req_ready_o = (sending & tx_ready_i) ? grant_q : '0;
  assign accept      = tx_valid_o & tx_ready_i;
  assign underrun    = sending & tx_ready_i & ~g_valid;
  assign pkt_done_o  = accept & g_last;
  assign tx_abort_o  = underrun | wdog_trip;
  assign pkt_end     = pkt_done_o | tx_abort_o;
  assign grant_o     = grant_q;
  assign busy_o      = (state_q != ST_IDLE);

  assign grant_ok = ~rx_active_i & (turn_q == '0) & (|req_valid_i);
  assign gap_last = (32'(gap_q) + 32'd1 >= IPG);
  assign ptr_d    = (gidx_q == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_q + PTR_W'(1);

  always_comb begin
    turn_d = turn_q;
    if (rx_active_i) begin
      turn_d = TURN_W'(TURNAROUND);
    end else if (turn_q != '0) begin
      turn_d = turn_q - TURN_W'(1);
    end
  end

`ifdef UTMI_TX_WDOG_EN
  localparam int unsigned LEN_W = cnt_w(MAX_LEN);

  logic [LEN_W-1:0] byte_q;

  assign wdog_trip = accept & ~g_last & (32'(byte_q) + 32'd1 >= MAX_LEN);

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_q <= '0;
    end else if (!sending) begin
      byte_q <= '0;
    end else if (accept) begin
      byte_q <= byte_q + LEN_W'(1);
    end
  end
`else
  assign wdog_trip = 1'b0;

  // MAX_LEN has no effect without the watchdog.
  if (MAX_LEN == 0) begin : g_no_len_limit
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      grant_q <= '0;
      turn_q  <= '0;
      gap_q   <= '0;
    end else begin
      turn_q <= turn_d;
      case (state_q)
        ST_IDLE: begin
          if (grant_ok) begin
            grant_q <= pick_grant;
            gidx_q  <= pick_idx;
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (pkt_end) begin
            grant_q <= '0;
            ptr_q   <= ptr_d;
            gap_q   <= '0;
            state_q <= (IPG == 0) ? ST_IDLE : ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_last) begin
            gap_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
